// File: rtl/conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// conv_seq_ctrl
//
// Initiator-side sequencer for the PIM convolution unit. One packed feature
// vector is accepted per upstream handshake and held on the unit's feature
// bus. For each crossbar column address 0..DEPTH-1 the unit is restarted
// (one-cycle low pulse on cu_rst_n), its completion flag is awaited and the
// result is captured. Each captured result is then offered downstream with
// its address and a last flag.
//
// Ports:
//   clk          clock
//   rst          synchronous active-low reset
//   in_valid     upstream vector valid
//   in_ready     upstream ready (high only in IDLE, low while rst is low)
//   in_data      packed feature vector (INPUT_SIZE*INPUT_P bits)
//   cu_feature   registered copy of in_data, held for the whole vector
//   cu_address   current crossbar column address
//   cu_rst_n     unit reset; low for one cycle per address and during rst
//   cu_done      unit completion flag (level, sticky until unit reset)
//   cu_result    unit result (OUT_P bits)
//   out_valid    captured result valid
//   out_ready    downstream ready
//   out_data     captured result, passed through unmodified
//   out_addr     address that produced out_data
//   out_last     high with the result for address DEPTH-1
//   busy         high in any state other than IDLE
//   err          sticky watchdog timeout flag
//
// Build option:
//   CONV_SEQ_TIMEOUT_EN  enables a RUN-state watchdog of TIMEOUT cycles.
//                        On expiry err is set, a zero result is emitted for
//                        that address and the sequence continues. Without
//                        it RUN waits indefinitely and err is tied low.
// ---------------------------------------------------------------------------
module conv_seq_ctrl #(
    parameter  int INPUT_SIZE = 49,
    parameter  int INPUT_P    = 8,
    parameter  int DEPTH      = 2,
    parameter  int OUT_P      = 8,
    parameter  int TIMEOUT    = 64,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INPUT_SIZE*INPUT_P-1:0] in_data,
    output logic [INPUT_SIZE*INPUT_P-1:0] cu_feature,
    output logic [AW-1:0]                 cu_address,
    output logic                          cu_rst_n,
    input  logic                          cu_done,
    input  logic [OUT_P-1:0]              cu_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_P-1:0]              out_data,
    output logic [AW-1:0]                 out_addr,
    output logic                          out_last,
    output logic                          busy,
    output logic                          err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [INPUT_SIZE*INPUT_P-1:0]   feature_q;
    logic [AW-1:0]                   addr_q;
    logic                            guard_q;
    logic [OUT_P-1:0]                out_data_q;
    logic [AW-1:0]                   out_addr_q;
    logic                            out_last_q;

    // Strobes decoded from the current state and inputs
    logic accept;
    logic capture;
    logic timeout_hit;
    logic advance;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wdog_q;
    logic            err_q;
`endif

    // -----------------------------------------------------------------------
    // Next-state and strobe decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                state_d = RUN;
            end

            RUN: begin
                // The first RUN cycle ignores cu_done: a level left over from
                // the previous run may still be visible right after restart.
                if (!guard_q && cu_done) begin
                    capture = 1'b1;
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (wdog_q == WD_LAST) begin
                    capture     = 1'b1;
                    timeout_hit = 1'b1;
                end
`endif
                if (capture) begin
                    state_d = OUTPUT;
                end
            end

            OUTPUT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = CLEAR;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            feature_q  <= '0;
            addr_q     <= '0;
            guard_q    <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // High exactly during the first RUN cycle after a restart
            guard_q <= (state_q == CLEAR);

            if (accept) begin
                feature_q <= in_data;
                addr_q    <= '0;
            end else if (advance) begin
                addr_q <= addr_q + AW'(1);
            end

            if (capture) begin
                out_data_q <= timeout_hit ? '0 : cu_result;
                out_addr_q <= addr_q;
                out_last_q <= (addr_q == LAST_ADDR);
            end
        end
    end

`ifdef CONV_SEQ_TIMEOUT_EN
    // Watchdog restarts from zero on every entry to RUN, so the count is
    // per address rather than per vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                wdog_q <= wdog_q + WD_W'(1);
            end else begin
                wdog_q <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign err            = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Gated by rst so upstream never sees ready while reset is held.
    assign in_ready   = rst && (state_q == IDLE);
    assign cu_rst_n   = rst && (state_q != CLEAR);
    assign cu_feature = feature_q;
    assign cu_address = addr_q;
    assign out_valid  = (state_q == OUTPUT);
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_seq_ctrl
//
// Directed bench for conv_seq_ctrl. A DEPTH=2 instance is driven with a
// behavioural unit model (done four cycles after restart, sticky until the
// next restart, per-address result table); a DEPTH=1 instance checks the
// single-address case. Define CONV_SEQ_TIMEOUT_EN for the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_conv_seq_ctrl;

    localparam int W   = 49 * 8;
    localparam int AW  = 1;

    localparam logic [W-1:0] VEC_A = {49{8'hA5}};
    localparam logic [W-1:0] VEC_B = {49{8'h5C}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;

    // DEPTH=2 instance
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data  = '0;
    logic [W-1:0]  cu_feature;
    logic [AW-1:0] cu_address;
    logic          cu_rst_n;
    logic          cu_done;
    logic [7:0]    cu_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          err;

    // DEPTH=1 instance
    logic          in_valid1 = 1'b0;
    logic          in_ready1;
    logic [W-1:0]  in_data1  = '0;
    logic [W-1:0]  cu_feature1;
    logic [0:0]    cu_address1;
    logic          cu_rst_n1;
    logic          cu_done1;
    logic [7:0]    cu_result1;
    logic          out_valid1;
    logic          out_ready1 = 1'b0;
    logic [7:0]    out_data1;
    logic [0:0]    out_addr1;
    logic          out_last1;
    logic          busy1;
    logic          err1;

    conv_seq_ctrl #(
        .INPUT_SIZE(49), .INPUT_P(8), .DEPTH(2), .OUT_P(8), .TIMEOUT(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cu_feature(cu_feature), .cu_address(cu_address), .cu_rst_n(cu_rst_n),
        .cu_done(cu_done), .cu_result(cu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .err(err)
    );

    conv_seq_ctrl #(
        .INPUT_SIZE(49), .INPUT_P(8), .DEPTH(1), .OUT_P(8), .TIMEOUT(16)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .cu_feature(cu_feature1), .cu_address(cu_address1), .cu_rst_n(cu_rst_n1),
        .cu_done(cu_done1), .cu_result(cu_result1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_addr(out_addr1), .out_last(out_last1), .busy(busy1), .err(err1)
    );

    // -----------------------------------------------------------------------
    // Unit model: counts cycles since cu_rst_n went high; done at count 4,
    // sticky until the next restart.
    // -----------------------------------------------------------------------
    logic [3:0] run_cnt;
    logic       stale_done = 1'b0;
    logic       never_done = 1'b0;

    always @(posedge clk) begin
        if (!cu_rst_n)              run_cnt <= 4'd0;
        else if (run_cnt != 4'hF)   run_cnt <= run_cnt + 4'd1;
    end

    assign cu_done   = !never_done && (stale_done || (run_cnt >= 4'd4));
    assign cu_result = (cu_address == 1'b0) ? 8'h3C : 8'h41;

    // DEPTH=1 unit: done level permanently high, fixed result
    assign cu_done1   = 1'b1;
    assign cu_result1 = 8'h5A;

    // Count CLEAR cycles seen outside of reset (one per restart pulse)
    int clr_cycles = 0;
    always @(posedge clk) begin
        if (rst && !cu_rst_n) clr_cycles <= clr_cycles + 1;
    end

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready (bounded), present one vector for one edge.
    task automatic accept(input logic [W-1:0] v, input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check(tag, W'(out_valid), W'(1));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    int lat;
    int clr0;
    int seen;

    initial begin
        // ---------------- reset values ----------------
        repeat (3) tick();
        check("rst_in_ready",  W'(in_ready),   W'(0));
        check("rst_out_valid", W'(out_valid),  W'(0));
        check("rst_out_data",  W'(out_data),   W'(0));
        check("rst_out_addr",  W'(out_addr),   W'(0));
        check("rst_out_last",  W'(out_last),   W'(0));
        check("rst_cu_feature", cu_feature,    W'(0));
        check("rst_cu_address", W'(cu_address), W'(0));
        check("rst_cu_rst_n",  W'(cu_rst_n),   W'(0));
        check("rst_busy",      W'(busy),       W'(0));
        check("rst_err",       W'(err),        W'(0));
        rst = 1'b1;
        tick();
        check("rst_rel_in_ready", W'(in_ready), W'(1));
        check("rst_rel_busy",     W'(busy),     W'(0));

        // ---------------- T1: nominal two-address sequence ----------------
        clr0 = clr_cycles;
        accept(VEC_A, "t1_acc");
        check("t1_clear_rst_n", W'(cu_rst_n),   W'(0));
        check("t1_clear_addr",  W'(cu_address), W'(0));
        check("t1_in_ready_lo", W'(in_ready),   W'(0));
        check("t1_busy",        W'(busy),       W'(1));
        wait_valid("t1_v0", lat);
        check("t1_lat0",   W'(lat),       W'(6));
        check("t1_data0",  W'(out_data),  W'(8'h3C));
        check("t1_addr0",  W'(out_addr),  W'(0));
        check("t1_last0",  W'(out_last),  W'(0));
        check("t1_feat0",  cu_feature,    VEC_A);
        handshake();
        check("t1_clear1_addr",  W'(cu_address), W'(1));
        check("t1_clear1_rst_n", W'(cu_rst_n),   W'(0));
        wait_valid("t1_v1", lat);
        check("t1_data1",  W'(out_data),  W'(8'h41));
        check("t1_addr1",  W'(out_addr),  W'(1));
        check("t1_last1",  W'(out_last),  W'(1));
        check("t1_feat1",  cu_feature,    VEC_A);
        handshake();
        check("t1_idle_busy",  W'(busy),      W'(0));
        check("t1_idle_ready", W'(in_ready),  W'(1));
        check("t1_idle_valid", W'(out_valid), W'(0));
        check("t1_clr_pulses", W'(clr_cycles - clr0), W'(2));
`ifndef CONV_SEQ_TIMEOUT_EN
        check("t1_err_tied", W'(err), W'(0));
`endif

        // ---------------- T2: stale done entering RUN ----------------
        stale_done = 1'b1;
        accept(VEC_B, "t2_acc");
        tick();
        check("t2_guard0",  W'(out_valid), W'(0));
        tick();
        check("t2_seen0",   W'(out_valid), W'(0));
        tick();
        check("t2_cap0",    W'(out_valid), W'(1));
        check("t2_data0",   W'(out_data),  W'(8'h3C));
        check("t2_feat",    cu_feature,    VEC_B);
        handshake();
        tick();
        check("t2_guard1",  W'(out_valid), W'(0));
        tick();
        check("t2_seen1",   W'(out_valid), W'(0));
        tick();
        check("t2_cap1",    W'(out_valid), W'(1));
        check("t2_data1",   W'(out_data),  W'(8'h41));
        check("t2_last1",   W'(out_last),  W'(1));
        handshake();
        stale_done = 1'b0;

        // ---------------- T3: downstream stall ----------------
        accept(VEC_A, "t3_acc");
        wait_valid("t3_v0", lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_hold_valid%0d", i), W'(out_valid), W'(1));
            check($sformatf("t3_hold_data%0d", i),  W'(out_data),  W'(8'h3C));
            check($sformatf("t3_hold_addr%0d", i),  W'(out_addr),  W'(0));
            check($sformatf("t3_hold_last%0d", i),  W'(out_last),  W'(0));
            check($sformatf("t3_hold_rstn%0d", i),  W'(cu_rst_n),  W'(1));
            check($sformatf("t3_hold_cuad%0d", i),  W'(cu_address), W'(0));
        end
        handshake();
        check("t3_next_addr",  W'(cu_address), W'(1));
        check("t3_next_rst_n", W'(cu_rst_n),   W'(0));
        // out_ready already high when out_valid rises: completes that cycle
        out_ready = 1'b1;
        wait_valid("t3_v1", lat);
        check("t3_last1", W'(out_last), W'(1));
        tick();
        out_ready = 1'b0;
        check("t3_early_valid", W'(out_valid), W'(0));
        check("t3_early_busy",  W'(busy),      W'(0));

        // ---------------- T4: reset during RUN of addr 1 ----------------
        accept(VEC_B, "t4_acc");
        wait_valid("t4_v0", lat);
        handshake();
        tick();
        rst = 1'b0;
        tick();
        check("t4_valid",    W'(out_valid),  W'(0));
        check("t4_cu_addr",  W'(cu_address), W'(0));
        check("t4_busy",     W'(busy),       W'(0));
        check("t4_rst_n",    W'(cu_rst_n),   W'(0));
        check("t4_in_ready", W'(in_ready),   W'(0));
        check("t4_out_last", W'(out_last),   W'(0));
        check("t4_feature",  cu_feature,     W'(0));
        rst = 1'b1;
        tick();
        check("t4_rel_ready", W'(in_ready), W'(1));
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("t4_no_emit", W'(seen), W'(0));

        // ---------------- T5: DEPTH=1 instance ----------------
        check("t5_ready", W'(in_ready1), W'(1));
        in_valid1 = 1'b1;
        in_data1  = VEC_A;
        tick();
        in_valid1 = 1'b0;
        check("t5_clear_rst_n", W'(cu_rst_n1), W'(0));
        tick();
        check("t5_guard",  W'(out_valid1), W'(0));
        tick();
        check("t5_seen",   W'(out_valid1), W'(0));
        tick();
        check("t5_valid",  W'(out_valid1), W'(1));
        check("t5_data",   W'(out_data1),  W'(8'h5A));
        check("t5_addr",   W'(out_addr1),  W'(0));
        check("t5_last",   W'(out_last1),  W'(1));
        check("t5_feat",   cu_feature1,    VEC_A);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("t5_idle_busy",  W'(busy1),     W'(0));
        check("t5_idle_ready", W'(in_ready1), W'(1));

`ifdef CONV_SEQ_TIMEOUT_EN
        // ---------------- T6: watchdog ----------------
        never_done = 1'b1;
        accept(VEC_A, "t6_acc");
        check("t6_err_pre", W'(err), W'(0));
        wait_valid("t6_v0", lat);
        check("t6_lat",   W'(lat),      W'(17));
        check("t6_err",   W'(err),      W'(1));
        check("t6_data0", W'(out_data), W'(0));
        check("t6_addr0", W'(out_addr), W'(0));
        handshake();
        check("t6_next_addr",  W'(cu_address), W'(1));
        check("t6_next_rst_n", W'(cu_rst_n),   W'(0));
        never_done = 1'b0;
        wait_valid("t6_v1", lat);
        check("t6_data1",   W'(out_data), W'(8'h41));
        check("t6_last1",   W'(out_last), W'(1));
        check("t6_err_sticky", W'(err),   W'(1));
        handshake();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
